// File: rtl/sync_ram_pkg.sv
// Shared types and helpers for the simple dual-port synchronous RAM.
package sync_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  function automatic int calc_be_w(input int data_w);
    return data_w / 8;
  endfunction

  // One byte lane of a byte-enable merge; callers loop over lanes so the
  // helper stays independent of the word width.
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/sync_ram_clear_fsm.sv
// Post-reset clear sequencer: walks every word once, then raises init_done.
// Holds the array closed to port traffic until the sweep (if any) is finished.
module sync_ram_clear_fsm
  import sync_ram_pkg::*;
#(
  parameter int ADDR_W         = 4,
  parameter int DEPTH          = 16,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              init_done_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic              init_done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_CLEAR;
      clr_addr_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (CLEAR_ON_RESET == 0 || clr_addr_q == LAST_ADDR) begin
            state_q     <= ST_READY;
            init_done_q <= 1'b1;
          end
          if (CLEAR_ON_RESET != 0) begin
            clr_addr_q <= clr_addr_q + 1'b1;
          end
        end
        default: begin
          state_q     <= ST_READY;
          init_done_q <= 1'b1;
        end
      endcase
    end
  end

  // rst gates the strobe so an interrupted sweep never writes on the reset edge.
  assign clr_we_o    = (state_q == ST_CLEAR) && !rst_i && (CLEAR_ON_RESET != 0);
  assign clr_addr_o  = clr_addr_q;
  assign init_done_o = init_done_q;

endmodule

// File: rtl/sync_ram_dp.sv
// Simple dual-port sync RAM: byte-enable writes, selectable read-during-write,
// optional output register, and a hardware clear sweep after reset.
module sync_ram_dp
  import sync_ram_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 4,
  parameter int DEPTH          = 16,
  parameter int OUT_REG        = 0,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int BE_W          = calc_be_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_done,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   wbe,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  sync_ram_clear_fsm #(
    .ADDR_W         (ADDR_W),
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_fsm (
    .clk_i       (clk),
    .rst_i       (rst),
    .init_done_o (init_done),
    .clr_we_o    (clr_we),
    .clr_addr_o  (clr_addr)
  );

  logic              wr_en, rd_en, rd_in_range, rdw_hit;
  logic [DATA_W-1:0] wr_old, wr_merged, rd_old, rdata_d;

  assign wr_en       = init_done & we & ({1'b0, waddr} < DEPTH_L);
  assign rd_en       = init_done & re;
  assign rd_in_range = {1'b0, raddr} < DEPTH_L;
  assign rdw_hit     = wr_en & rd_en & (waddr == raddr);

  assign wr_old = wr_en ? mem_q[waddr] : '0;
  assign rd_old = rd_in_range ? mem_q[raddr] : '0;

  always_comb begin
    wr_merged = wr_old;
    for (int i = 0; i < BE_W; i++) begin
      wr_merged[8*i +: 8] = merge_byte(wr_old[8*i +: 8], wdata[8*i +: 8], wbe[i]);
    end
  end

  // Write-first forwards the merged word; read-first sees the array before the write.
  assign rdata_d = (RDW_MODE == RDW_WRITE_FIRST && rdw_hit) ? wr_merged : rd_old;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_en) begin
      mem_q[waddr] <= wr_merged;
    end
  end

  logic [DATA_W-1:0] rdata1_q;
  logic              rvld1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata1_q <= '0;
      rvld1_q  <= 1'b0;
    end else begin
      rvld1_q <= rd_en;
      if (rd_en) begin
        rdata1_q <= rdata_d;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] rdata2_q;
      logic              rvld2_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          rdata2_q <= '0;
          rvld2_q  <= 1'b0;
        end else begin
          rvld2_q <= rvld1_q;
          if (rvld1_q) begin
            rdata2_q <= rdata1_q;
          end
        end
      end

      assign rdata  = rdata2_q;
      assign rvalid = rvld2_q;
    end else begin : g_no_out_reg
      assign rdata  = rdata1_q;
      assign rvalid = rvld1_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_ram_dp.sv
// Bench for sync_ram_dp: two configurations share one stimulus stream and are
// checked against constants and a queue-based reference model.
module tb_sync_ram_dp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, we, re;
  logic [3:0]  waddr, raddr;
  logic [15:0] wdata;
  logic [1:0]  wbe;

  logic        done_a, vld_a;
  logic [7:0]  dat_a;
  logic        done_b, vld_b;
  logic [15:0] dat_b;

  // A: defaults (8-bit, 16 deep, latency 1, read-first)
  sync_ram_dp #(
    .DATA_W(8), .ADDR_W(4), .DEPTH(16), .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)
  ) u_dut_a (
    .clk(clk), .rst(rst), .init_done(done_a),
    .we(we), .waddr(waddr), .wdata(wdata[7:0]), .wbe(wbe[0:0]),
    .re(re), .raddr(raddr), .rdata(dat_a), .rvalid(vld_a)
  );

  // B: 16-bit, 12 deep, latency 2, write-first
  sync_ram_dp #(
    .DATA_W(16), .ADDR_W(4), .DEPTH(12), .OUT_REG(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .init_done(done_b),
    .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .re(re), .raddr(raddr), .rdata(dat_b), .rvalid(vld_b)
  );

  typedef struct {
    int          id;
    int          due;
    logic [15:0] d;
  } rd_t;

  rd_t         pend[$];
  int          depth_m [2] = '{16, 12};
  int          oreg_m  [2] = '{0, 1};
  int          rdw_m   [2] = '{0, 1};
  logic [15:0] lane_m  [2] = '{16'h00FF, 16'hFFFF};
  logic [15:0] mem_m   [2][16];
  bit          rdy_m   [2];
  int          cnt_m   [2];
  bit          exp_vld [2];
  logic [15:0] exp_dat [2];
  int          n_edge;
  int          vecs;
  int          errs;

  task automatic model_edge(input int id, input bit r, input bit w, input bit rd,
                            input logic [3:0] wa, input logic [3:0] ra,
                            input logic [15:0] wd, input logic [1:0] be);
    logic [15:0] m, old, merged, d;
    if (r) begin
      rdy_m[id]   = 1'b0;
      cnt_m[id]   = 0;
      exp_vld[id] = 1'b0;
      exp_dat[id] = '0;
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (pend[i].id == id) pend.delete(i);
      end
      return;
    end
    m = {{8{be[1]}}, {8{be[0]}}} & lane_m[id];
    if (rdy_m[id]) begin
      old    = (int'(wa) < depth_m[id]) ? mem_m[id][wa] : 16'h0;
      merged = (old & ~m) | (wd & m);
      if (rd) begin
        d = (int'(ra) < depth_m[id]) ? mem_m[id][ra] : 16'h0;
        if (w && wa == ra && rdw_m[id] == 1 && int'(wa) < depth_m[id]) d = merged;
        pend.push_back('{id, n_edge + oreg_m[id], d});
      end
      if (w && int'(wa) < depth_m[id]) mem_m[id][wa] = merged;
    end else begin
      cnt_m[id]++;
      if (cnt_m[id] == depth_m[id]) begin
        rdy_m[id] = 1'b1;
        for (int i = 0; i < 16; i++) mem_m[id][i] = '0;
      end
    end
    exp_vld[id] = 1'b0;
    for (int i = 0; i < pend.size(); i++) begin
      if (pend[i].id == id) begin
        if (pend[i].due == n_edge) begin
          exp_vld[id] = 1'b1;
          exp_dat[id] = pend[i].d;
          pend.delete(i);
        end
        break;
      end
    end
  endtask

  task automatic step();
    logic r, w, rd;
    logic [3:0] wa, ra;
    logic [15:0] wd;
    logic [1:0] be;
    r = rst; w = we; rd = re; wa = waddr; ra = raddr; wd = wdata; be = wbe;
    @(posedge clk);
    n_edge++;
    model_edge(0, r, w, rd, wa, ra, wd, be);
    model_edge(1, r, w, rd, wa, ra, wd, be);
    @(negedge clk);
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; waddr = '0; raddr = '0; wdata = '0; wbe = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    vecs++;
    if (done_a !== 1'b0 || done_b !== 1'b0) begin
      errs++; $display("FAIL reset_init_done got a=%b b=%b want 0 0", done_a, done_b);
    end
    vecs++;
    if (vld_a !== 1'b0 || vld_b !== 1'b0 || dat_a !== 8'h00 || dat_b !== 16'h0000) begin
      errs++; $display("FAIL reset_outputs got vld %b/%b dat %h/%h want 0", vld_a, vld_b, dat_a, dat_b);
    end
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      vecs++;
      if (done_a !== (k >= 16) || done_b !== (k >= 12)) begin
        errs++; $display("FAIL sweep_timing edge %0d got a=%b b=%b want %b %b", k, done_a, done_b, k >= 16, k >= 12);
      end
    end
  endtask

  task automatic test_read_all();
    for (int k = 0; k < 16; k++) begin
      re = 1'b1; raddr = 4'(k);
      step();
      vecs++;
      if (vld_a !== 1'b1 || dat_a !== 8'h00) begin
        errs++; $display("FAIL cleared_read_a addr %0d got vld=%b dat=%h want 1 00", k, vld_a, dat_a);
      end
      vecs++;
      if (vld_b !== (k > 0) || dat_b !== 16'h0000) begin
        errs++; $display("FAIL cleared_read_b step %0d got vld=%b dat=%h want %b 0000", k, vld_b, dat_b, k > 0);
      end
    end
    idle();
    step();
    vecs++;
    if (vld_a !== 1'b0 || vld_b !== 1'b1) begin
      errs++; $display("FAIL read_drain got vld a=%b b=%b want 0 1", vld_a, vld_b);
    end
    step();
    vecs++;
    if (vld_b !== 1'b0) begin
      errs++; $display("FAIL read_drain_b got vld=%b want 0", vld_b);
    end
  endtask

  task automatic test_back_to_back();
    we = 1'b1; wbe = 2'b01; waddr = 4'd0; wdata = 16'hC3AA;
    step();
    waddr = 4'd1; wdata = 16'hC3BB;
    step();
    idle(); re = 1'b1; raddr = 4'd0;
    step();
    vecs++;
    if (vld_a !== 1'b1 || dat_a !== 8'hAA || vld_b !== 1'b0) begin
      errs++; $display("FAIL b2b_first got a=%b/%h b vld=%b want 1/AA 0", vld_a, dat_a, vld_b);
    end
    raddr = 4'd1;
    step();
    vecs++;
    if (vld_a !== 1'b1 || dat_a !== 8'hBB || vld_b !== 1'b1 || dat_b !== 16'h00AA) begin
      errs++; $display("FAIL b2b_second got a=%b/%h b=%b/%h want 1/BB 1/00AA", vld_a, dat_a, vld_b, dat_b);
    end
    idle();
    step();
    vecs++;
    if (vld_a !== 1'b0 || dat_a !== 8'hBB || vld_b !== 1'b1 || dat_b !== 16'h00BB) begin
      errs++; $display("FAIL b2b_tail got a=%b/%h b=%b/%h want 0/BB 1/00BB", vld_a, dat_a, vld_b, dat_b);
    end
    step();
    vecs++;
    if (vld_b !== 1'b0 || dat_b !== 16'h00BB) begin
      errs++; $display("FAIL b2b_hold got b=%b/%h want 0/00BB", vld_b, dat_b);
    end
  endtask

  task automatic test_byte_enable();
    we = 1'b1; waddr = 4'd3; wdata = 16'h1234; wbe = 2'b11;
    step();
    wdata = 16'hABCD; wbe = 2'b01;
    step();
    wdata = 16'hFFFF; wbe = 2'b00;
    step();
    idle(); re = 1'b1; raddr = 4'd3;
    step();
    vecs++;
    if (vld_a !== 1'b1 || dat_a !== 8'hCD) begin
      errs++; $display("FAIL byte_enable_a got %b/%h want 1/CD", vld_a, dat_a);
    end
    idle();
    step();
    vecs++;
    if (vld_b !== 1'b1 || dat_b !== 16'h12CD) begin
      errs++; $display("FAIL byte_enable_b got %b/%h want 1/12CD", vld_b, dat_b);
    end
  endtask

  task automatic test_rdw();
    we = 1'b1; waddr = 4'd5; wdata = 16'h0011; wbe = 2'b11;
    step();
    re = 1'b1; raddr = 4'd5; wdata = 16'h0022;
    step();
    vecs++;
    if (vld_a !== 1'b1 || dat_a !== 8'h11) begin
      errs++; $display("FAIL rdw_read_first got %b/%h want 1/11", vld_a, dat_a);
    end
    we = 1'b0;
    step();
    vecs++;
    if (dat_a !== 8'h22 || vld_b !== 1'b1 || dat_b !== 16'h0022) begin
      errs++; $display("FAIL rdw_write_first got a=%h b=%b/%h want 22 1/0022", dat_a, vld_b, dat_b);
    end
    idle();
    step();
    vecs++;
    if (vld_b !== 1'b1 || dat_b !== 16'h0022) begin
      errs++; $display("FAIL rdw_after_b got %b/%h want 1/0022", vld_b, dat_b);
    end
    we = 1'b1; waddr = 4'd6; wdata = 16'h1111; wbe = 2'b11;
    step();
    re = 1'b1; raddr = 4'd6; wdata = 16'h22EE; wbe = 2'b01;
    step();
    vecs++;
    if (dat_a !== 8'h11) begin
      errs++; $display("FAIL rdw_partial_a got %h want 11", dat_a);
    end
    we = 1'b0;
    step();
    vecs++;
    if (dat_a !== 8'hEE || vld_b !== 1'b1 || dat_b !== 16'h11EE) begin
      errs++; $display("FAIL rdw_partial_b got a=%h b=%b/%h want EE 1/11EE", dat_a, vld_b, dat_b);
    end
    idle();
    step();
    vecs++;
    if (dat_b !== 16'h11EE) begin
      errs++; $display("FAIL rdw_partial_after got %h want 11EE", dat_b);
    end
  endtask

  task automatic test_out_of_range();
    we = 1'b1; waddr = 4'd14; wdata = 16'h0077; wbe = 2'b11;
    step();
    idle(); re = 1'b1; raddr = 4'd14;
    step();
    vecs++;
    if (vld_a !== 1'b1 || dat_a !== 8'h77) begin
      errs++; $display("FAIL in_range_a got %b/%h want 1/77", vld_a, dat_a);
    end
    idle();
    step();
    vecs++;
    if (vld_b !== 1'b1 || dat_b !== 16'h0000) begin
      errs++; $display("FAIL out_of_range_b got %b/%h want 1/0000", vld_b, dat_b);
    end
    we = 1'b1; waddr = 4'd11; wdata = 16'h005A; wbe = 2'b11;
    step();
    idle(); re = 1'b1; raddr = 4'd11;
    step();
    vecs++;
    if (dat_a !== 8'h5A) begin
      errs++; $display("FAIL last_word_a got %h want 5A", dat_a);
    end
    idle();
    step();
    vecs++;
    if (vld_b !== 1'b1 || dat_b !== 16'h005A) begin
      errs++; $display("FAIL last_word_b got %b/%h want 1/005A", vld_b, dat_b);
    end
  endtask

  task automatic test_sweep_restart();
    idle(); re = 1'b1; raddr = 4'd11;
    step();
    rst = 1'b1; re = 1'b0;
    step();
    vecs++;
    if (vld_a !== 1'b0 || vld_b !== 1'b0 || dat_b !== 16'h0000) begin
      errs++; $display("FAIL inflight_discard got vld %b/%b dat_b %h want 0 0 0000", vld_a, vld_b, dat_b);
    end
    rst = 1'b0;
    we = 1'b1; waddr = 4'd2; wdata = 16'h00FF; wbe = 2'b11; re = 1'b1; raddr = 4'd2;
    for (int k = 1; k <= 5; k++) begin
      step();
      vecs++;
      if (done_a !== 1'b0 || done_b !== 1'b0 || vld_a !== 1'b0 || vld_b !== 1'b0) begin
        errs++; $display("FAIL sweep_quiet %0d got done %b/%b vld %b/%b want 0", k, done_a, done_b, vld_a, vld_b);
      end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k >= 12) idle();
      step();
      vecs++;
      if (done_a !== (k >= 16) || done_b !== (k >= 12) || vld_a !== 1'b0 || vld_b !== 1'b0) begin
        errs++; $display("FAIL restart_timing %0d got done %b/%b vld %b/%b want %b %b 0 0",
                         k, done_a, done_b, vld_a, vld_b, k >= 16, k >= 12);
      end
    end
    re = 1'b1; raddr = 4'd2;
    step();
    vecs++;
    if (vld_a !== 1'b1 || dat_a !== 8'h00) begin
      errs++; $display("FAIL sweep_write_ignored got %b/%h want 1/00", vld_a, dat_a);
    end
    idle();
    step();
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      rst   = ($urandom_range(0, 199) == 0);
      we    = 1'($urandom_range(0, 1));
      re    = 1'($urandom_range(0, 1));
      waddr = 4'($urandom_range(0, 15));
      raddr = ($urandom_range(0, 1) == 1) ? waddr : 4'($urandom_range(0, 15));
      wdata = 16'($urandom);
      wbe   = 2'($urandom);
      step();
      vecs++;
      if (done_a !== rdy_m[0] || done_b !== rdy_m[1]) begin
        errs++; $display("FAIL rand_init_done cyc %0d got %b/%b want %b/%b", k, done_a, done_b, rdy_m[0], rdy_m[1]);
      end
      vecs++;
      if (vld_a !== exp_vld[0] || dat_a !== exp_dat[0][7:0]) begin
        errs++; $display("FAIL rand_read_a cyc %0d got %b/%h want %b/%h", k, vld_a, dat_a, exp_vld[0], exp_dat[0][7:0]);
      end
      vecs++;
      if (vld_b !== exp_vld[1] || dat_b !== exp_dat[1]) begin
        errs++; $display("FAIL rand_read_b cyc %0d got %b/%h want %b/%h", k, vld_b, dat_b, exp_vld[1], exp_dat[1]);
      end
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    vecs   = 0;
    errs   = 0;
    n_edge = 0;
    rst    = 1'b1;
    idle();
    test_reset();
    test_read_all();
    test_back_to_back();
    test_byte_enable();
    test_rdw();
    test_out_of_range();
    test_sweep_restart();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
